// File: rtl/game_timing_pkg.sv
// Shared timing definitions for the game tick scheduler: FSM encoding and tick divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package game_timing_pkg;

  // Scheduler mode / step-button tracking states.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_IDLE = 2'd1,
    STEP_HELD = 2'd2
  } sched_state_t;

  // Clock cycles per free-run game tick (integer division).
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Signal bundle between the game logic side and the tick scheduler.
// Latency: n/a (wires only).
// Backpressure: game_busy holds off tick issue; ticks are never queued beyond one.
interface game_tick_scheduler_if;
  logic        switch;
  logic        step_btn;
  logic        game_busy;
  logic        tick;
  logic        pix_en;
  logic        step_mode;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  // Game / board side: drives mode, button and busy, consumes the tick.
  modport master (
    output switch, step_btn, game_busy,
    input  tick, pix_en, step_mode, frame_count, overrun_count
  );

  // Scheduler side.
  modport slave (
    input  switch, step_btn, game_busy,
    output tick, pix_en, step_mode, frame_count, overrun_count
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce for one raw pushbutton.
// Latency: 2 sync cycles + CYCLES stable cycles before o_level follows the button.
// Backpressure: none; o_rise is a one-cycle pulse on the accepted 0->1 change.
module btn_debounce #(
  parameter int CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept a new level only after CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync;
          r_rise  <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: free-run prescaler or debounced single-step, one pending tick, VGA pixel enable.
// Latency: tick issues the cycle after a due event; step_mode follows switch after 3 cycles.
// Backpressure: game_busy holds the single pending tick; extra due events are counted as overruns.
module game_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 60,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        switch,
  input  logic        step_btn,
  input  logic        game_busy,
  output logic        tick,
  output logic        pix_en,
  output logic        step_mode,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          r_sw_meta;
  logic          r_sw_sync;
  logic          r_step_mode;
  sched_state_t  r_state;
  logic [PW-1:0] r_pre;
  logic          r_pend;
  logic          r_tick;
  logic          r_pix;
  logic [15:0]   r_frame;
  logic [7:0]    r_overrun;

  logic w_btn_level;
  logic w_btn_rise;
  logic w_mode_chg;
  logic w_due;
  logic w_issue;

  btn_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk     (clk_50mhz),
    .rst     (rst),
    .i_btn   (step_btn),
    .o_level (w_btn_level),
    .o_rise  (w_btn_rise)
  );

  // Two-flop synchronizer for the mode switch.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_sw_meta <= 1'b0;
      r_sw_sync <= 1'b0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  // r_step_mode is the mode the FSM is currently in; a mismatch is a synced switch change.
  assign w_mode_chg = r_sw_sync ^ r_step_mode;

  // Due event: prescaler wrap in RUN, debounced press in STEP_IDLE; suppressed on a mode change.
  always_comb begin
    w_due = 1'b0;
    if (!w_mode_chg) begin
      case (r_state)
        RUN:       w_due = (r_pre == PRE_LAST);
        STEP_IDLE: w_due = w_btn_rise;
        default:   w_due = 1'b0;
      endcase
    end
  end

  // A mode change drops the pending tick, so it must not issue on that cycle either.
  assign w_issue = r_pend & ~game_busy & ~w_mode_chg;

  // Mode FSM with prescaler; any mode change restarts from a cleared prescaler.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state     <= RUN;
      r_pre       <= '0;
      r_step_mode <= 1'b0;
    end else if (w_mode_chg) begin
      r_step_mode <= r_sw_sync;
      r_state     <= r_sw_sync ? STEP_IDLE : RUN;
      r_pre       <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        end
        STEP_IDLE: begin
          if (w_btn_rise) r_state <= STEP_HELD;
        end
        STEP_HELD: begin
          if (!w_btn_level) r_state <= STEP_IDLE;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Single pending tick, issue, frame and overrun counters. A due event coinciding with an
  // issue re-arms pending; that is not an overrun since no tick is lost.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_frame   <= '0;
      r_overrun <= '0;
    end else begin
      r_tick <= w_issue;
      r_pend <= ~w_mode_chg & (w_due | (r_pend & ~w_issue));
      if (w_issue) r_frame <= r_frame + 16'd1;
      if (w_due && r_pend && !w_issue && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
    end
  end

  // 25 MHz pixel enable: free-running toggle.
  always_ff @(posedge clk_50mhz) begin
    if (rst) r_pix <= 1'b0;
    else     r_pix <= ~r_pix;
  end

  assign tick          = r_tick;
  assign pix_en        = r_pix;
  assign step_mode     = r_step_mode;
  assign frame_count   = r_frame;
  assign overrun_count = r_overrun;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: free-run, step with bounce, busy stall, mode switch,
// reset mid-operation, counter wrap and overrun saturation.
// Edge numbering: E0 is the first clock edge that samples rst low.
module tb_game_tick_scheduler;
  import game_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  game_tick_scheduler_if bus ();
  game_tick_scheduler_if bus2 ();

  // TICK_DIV = 10, debounce 4 cycles.
  game_tick_scheduler #(.CLK_HZ(600), .TICK_HZ(60), .DEBOUNCE_CYCLES(4)) dut (
    .clk_50mhz     (clk),
    .rst           (rst),
    .switch        (bus.switch),
    .step_btn      (bus.step_btn),
    .game_busy     (bus.game_busy),
    .tick          (bus.tick),
    .pix_en        (bus.pix_en),
    .step_mode     (bus.step_mode),
    .frame_count   (bus.frame_count),
    .overrun_count (bus.overrun_count)
  );

  // TICK_DIV = 1: a due event every cycle, for fast wrap / saturation.
  game_tick_scheduler #(.CLK_HZ(60), .TICK_HZ(60), .DEBOUNCE_CYCLES(4)) dut2 (
    .clk_50mhz     (clk),
    .rst           (rst),
    .switch        (bus2.switch),
    .step_btn      (bus2.step_btn),
    .game_busy     (bus2.game_busy),
    .tick          (bus2.tick),
    .pix_en        (bus2.pix_en),
    .step_mode     (bus2.step_mode),
    .frame_count   (bus2.frame_count),
    .overrun_count (bus2.overrun_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.switch = 1'b0; bus.step_btn = 1'b0; bus.game_busy = 1'b0;
    bus2.switch = 1'b0; bus2.step_btn = 1'b0; bus2.game_busy = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
    n_cmp++; if (bus.pix_en !== 1'b0) begin n_bad++; $display("FAIL reset_pix: got %b want 0", bus.pix_en); end
    n_cmp++; if (bus.frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frame: got %0d want 0", bus.frame_count); end
    n_cmp++; if (bus.overrun_count !== 8'd0) begin n_bad++; $display("FAIL reset_overrun: got %0d want 0", bus.overrun_count); end
    n_cmp++; if (bus.step_mode !== 1'b0) begin n_bad++; $display("FAIL reset_step_mode: got %b want 0", bus.step_mode); end
    step();
    n_cmp++; if (bus.pix_en !== 1'b1) begin n_bad++; $display("FAIL pix_e0: got %b want 1", bus.pix_en); end
    step();
    n_cmp++; if (bus.pix_en !== 1'b0) begin n_bad++; $display("FAIL pix_e1: got %b want 0", bus.pix_en); end
  endtask

  task automatic test_free_run();
    logic exp;
    do_reset();
    for (int e = 0; e <= 50; e++) begin
      step();
      exp = (e > 0) && (e % 10 == 0);
      n_cmp++;
      if (bus.tick !== exp) begin n_bad++; $display("FAIL free_run_tick E%0d: got %b want %b", e, bus.tick, exp); end
    end
    n_cmp++; if (bus.frame_count !== 16'd5) begin n_bad++; $display("FAIL free_run_frame: got %0d want 5", bus.frame_count); end
  endtask

  task automatic test_step_bounce();
    bit gl [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit rb [3] = '{1'b0, 1'b1, 1'b0};
    int press_ticks = 0;
    int rel_ticks = 0;
    int press2_ticks = 0;
    do_reset();
    bus.switch = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (bus.step_mode !== 1'b1) begin n_bad++; $display("FAIL step_mode_set: got %b want 1", bus.step_mode); end
    for (int i = 0; i < 7; i++) begin bus.step_btn = gl[i]; step(); if (bus.tick) press_ticks++; end
    for (int i = 0; i < 20; i++) begin bus.step_btn = 1'b1; step(); if (bus.tick) press_ticks++; end
    for (int i = 0; i < 3; i++) begin bus.step_btn = rb[i]; step(); if (bus.tick) rel_ticks++; end
    for (int i = 0; i < 20; i++) begin bus.step_btn = 1'b0; step(); if (bus.tick) rel_ticks++; end
    n_cmp++; if (press_ticks != 1) begin n_bad++; $display("FAIL step_press_ticks: got %0d want 1", press_ticks); end
    n_cmp++; if (rel_ticks != 0) begin n_bad++; $display("FAIL step_release_ticks: got %0d want 0", rel_ticks); end
    n_cmp++; if (bus.frame_count !== 16'd1) begin n_bad++; $display("FAIL step_frame: got %0d want 1", bus.frame_count); end
    for (int i = 0; i < 12; i++) begin bus.step_btn = 1'b1; step(); if (bus.tick) press2_ticks++; end
    n_cmp++; if (press2_ticks != 1) begin n_bad++; $display("FAIL step_press2_ticks: got %0d want 1", press2_ticks); end
    n_cmp++; if (bus.frame_count !== 16'd2) begin n_bad++; $display("FAIL step_frame2: got %0d want 2", bus.frame_count); end
  endtask

  task automatic test_busy_stall();
    logic exp;
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      bus.game_busy = (e >= 9) && (e <= 33);
      step();
      exp = (e == 34) || (e == 40);
      n_cmp++;
      if (bus.tick !== exp) begin n_bad++; $display("FAIL busy_tick E%0d: got %b want %b", e, bus.tick, exp); end
      if (e == 33) begin
        n_cmp++;
        if (bus.overrun_count !== 8'd2) begin n_bad++; $display("FAIL busy_overrun: got %0d want 2", bus.overrun_count); end
      end
    end
    n_cmp++; if (bus.frame_count !== 16'd2) begin n_bad++; $display("FAIL busy_frame: got %0d want 2", bus.frame_count); end
  endtask

  task automatic test_mode_switch();
    logic exp;
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      bus.switch = (e >= 5) && (e <= 20);
      step();
      exp = (e == 34);
      n_cmp++;
      if (bus.tick !== exp) begin n_bad++; $display("FAIL mode_tick E%0d: got %b want %b", e, bus.tick, exp); end
      if (e == 6) begin
        n_cmp++;
        if (dut.r_pre !== 4'd7) begin n_bad++; $display("FAIL mode_pre_before: got %0d want 7", dut.r_pre); end
      end
      if (e == 7) begin
        n_cmp++;
        if (dut.r_state !== STEP_IDLE) begin n_bad++; $display("FAIL mode_state: got %0d want %0d", dut.r_state, STEP_IDLE); end
        n_cmp++;
        if (bus.step_mode !== 1'b1) begin n_bad++; $display("FAIL mode_step_mode: got %b want 1", bus.step_mode); end
        n_cmp++;
        if (dut.r_pre !== 4'd0) begin n_bad++; $display("FAIL mode_pre_clear: got %0d want 0", dut.r_pre); end
      end
      if (e == 23) begin
        n_cmp++;
        if (bus.step_mode !== 1'b0) begin n_bad++; $display("FAIL mode_back_run: got %b want 0", bus.step_mode); end
      end
    end
  endtask

  task automatic test_mode_drop();
    int ticks = 0;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      bus.game_busy = (e >= 9) && (e <= 15);
      bus.switch = (e >= 12);
      step();
      if (bus.tick) ticks++;
      if (e == 13) begin
        n_cmp++;
        if (dut.r_pend !== 1'b1) begin n_bad++; $display("FAIL drop_pend_before: got %b want 1", dut.r_pend); end
      end
      if (e == 14) begin
        n_cmp++;
        if (dut.r_pend !== 1'b0) begin n_bad++; $display("FAIL drop_pend_after: got %b want 0", dut.r_pend); end
      end
    end
    n_cmp++; if (ticks != 0) begin n_bad++; $display("FAIL drop_ticks: got %0d want 0", ticks); end
  endtask

  task automatic test_reset_mid();
    logic exp;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      bus.game_busy = (e >= 26);
      step();
    end
    n_cmp++; if (bus.frame_count !== 16'd2) begin n_bad++; $display("FAIL rstmid_frame_pre: got %0d want 2", bus.frame_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.game_busy = 1'b0;
    n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL rstmid_tick: got %b want 0", bus.tick); end
    n_cmp++; if (bus.pix_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_pix: got %b want 0", bus.pix_en); end
    n_cmp++; if (bus.frame_count !== 16'd0) begin n_bad++; $display("FAIL rstmid_frame: got %0d want 0", bus.frame_count); end
    n_cmp++; if (bus.overrun_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_overrun: got %0d want 0", bus.overrun_count); end
    for (int e = 0; e <= 12; e++) begin
      step();
      exp = (e == 10);
      n_cmp++;
      if (bus.tick !== exp) begin n_bad++; $display("FAIL rstmid_after_tick E%0d: got %b want %b", e, bus.tick, exp); end
    end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    for (int i = 0; i < 65536; i++) step();
    n_cmp++; if (bus2.frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_ffff: got %0d want 65535", bus2.frame_count); end
    step();
    n_cmp++; if (bus2.frame_count !== 16'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", bus2.frame_count); end
    bus2.game_busy = 1'b1;
    for (int i = 0; i < 100; i++) step();
    n_cmp++; if (bus2.overrun_count !== 8'd100) begin n_bad++; $display("FAIL overrun_100: got %0d want 100", bus2.overrun_count); end
    for (int i = 0; i < 200; i++) step();
    n_cmp++; if (bus2.overrun_count !== 8'd255) begin n_bad++; $display("FAIL overrun_sat: got %0d want 255", bus2.overrun_count); end
    n_cmp++; if (bus2.frame_count !== 16'd0) begin n_bad++; $display("FAIL busy_hold_frame: got %0d want 0", bus2.frame_count); end
    bus2.game_busy = 1'b0;
    step();
    n_cmp++; if (bus2.tick !== 1'b1) begin n_bad++; $display("FAIL release_tick: got %b want 1", bus2.tick); end
  endtask

  initial begin
    bus.switch = 1'b0; bus.step_btn = 1'b0; bus.game_busy = 1'b0;
    bus2.switch = 1'b0; bus2.step_btn = 1'b0; bus2.game_busy = 1'b0;
    test_reset();
    test_free_run();
    test_step_bounce();
    test_busy_stall();
    test_mode_switch();
    test_mode_drop();
    test_reset_mid();
    test_wrap_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 60: free-run game tick rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ (integer division, 833_333 at defaults).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500_000: number of stable cycles (10 ms) required to accept a step_btn level.
REQ-004 SHALL have port clk_50mhz, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port switch, input, 1 bit: mode select, asynchronous; 0 = free-run, 1 = single-step.
REQ-007 SHALL have port step_btn, input, 1 bit: raw, bouncing, asynchronous step pushbutton; 1 = pressed.
REQ-008 SHALL have port game_busy, input, 1 bit: game logic still processing the previous tick.
REQ-009 SHALL have port tick, output, 1 bit: one-cycle game-update enable.
REQ-010 SHALL have port pix_en, output, 1 bit: 25 MHz VGA pixel enable, high on alternate cycles.
REQ-011 SHALL have port step_mode, output, 1 bit: synchronized, registered copy of switch.
REQ-012 SHALL have port frame_count, output, 16 bits: number of ticks issued.
REQ-013 SHALL have port overrun_count, output, 8 bits: number of ticks that fell due while one was already pending.

Function
REQ-014 SHALL pass switch and step_btn through 2-flop synchronizers before any use; latency 2 cycles.
REQ-015 SHALL debounce synced step_btn with a counter: the accepted level changes only after DEBOUNCE_CYCLES consecutive cycles differing from it; any agreeing sample clears the counter.
REQ-016 SHALL use an FSM with states RUN, STEP_IDLE, STEP_HELD.
REQ-017 In RUN, SHALL run a prescaler 0..TICK_DIV-1 and raise a due event on the cycle the prescaler wraps to 0.
REQ-018 In STEP_IDLE, SHALL raise a due event on a debounced 0->1 edge and move to STEP_HELD; STEP_HELD returns to STEP_IDLE on debounced release, so one press yields exactly one due event.
REQ-019 SHALL, on any change of synced switch, move to RUN or STEP_IDLE (STEP_IDLE even if the button is held), clear the prescaler, and drop any pending tick.
REQ-020 SHALL, on a due event, set an internal pending flag.
REQ-021 SHALL assert tick for exactly one cycle, in the cycle after pending is set, when game_busy is low; it SHALL then clear pending.
REQ-022 SHALL, while game_busy is high, hold pending and issue no tick.
REQ-023 SHALL, on a due event while pending is already set, keep a single pending tick and increment overrun_count, saturating at 255.
REQ-024 SHALL, when a due event and tick issue coincide, let the due event win: pending stays set.
REQ-025 SHALL increment frame_count on every tick, wrapping from 0xFFFF to 0.
REQ-026 SHALL toggle pix_en every cycle independently of mode.
REQ-027 SHALL drive all outputs from registers; there is no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, when rst is high at a clock edge, force: state = RUN; prescaler, debounce counter, pending = 0; tick = 0; pix_en = 0; frame_count = 0; overrun_count = 0; step_mode = 0; synchronizer and debounced levels = 0.
REQ-029 SHALL, when reset is applied mid-operation, discard any pending tick; the first free-run tick falls TICK_DIV cycles after rst deasserts.

Structure
REQ-030 SHALL place the FSM state encoding and the TICK_DIV derivation in shared package game_timing_pkg.
REQ-031 SHALL implement the debounce filter, including its synchronizer, as sub-module btn_debounce; it is reused for other buttons.

Verification
REQ-032 Free-run: TICK_DIV=10, switch=0, busy=0 -> tick every 10 cycles, first at cycle 10 after reset; frame_count=5 after 50 cycles.
REQ-033 Step with bounce: switch=1, DEBOUNCE_CYCLES=4, press with 3 glitches then hold 20 cycles -> exactly one tick; frame_count=1; no tick on release.
REQ-034 Busy stall: tick due while busy=1 for 25 cycles (TICK_DIV=10) -> no tick while busy; overrun_count=2; one tick on the cycle after busy falls.
REQ-035 Mode switch mid-count: switch 0->1 with prescaler at 7 -> no tick, pending cleared, state STEP_IDLE; switch 1->0 -> next tick 10 cycles after the synced change.
REQ-036 Wrap and saturation: preload via 65536 ticks -> frame_count=0; 300 overruns -> overrun_count=255.
REQ-037 Reset mid-operation: rst pulsed while pending and busy=1 -> all outputs at reset values next cycle; no stale tick after busy falls.
